// File: rtl/stack_seq.sv
// Byte-wide memory stack sequencer: PUSH/POP/XTHL/LDSP on a 16-bit word stack.
// Optional overflow/underflow guard is built in when STACK_GUARD_EN is defined.
module stack_seq #(
    parameter logic [15:0] SP_INIT     = 16'h0000,
    parameter logic [15:0] STACK_LIMIT = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        stk_fault,
    output logic [15:0] mem_addr,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] sp
);

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_XTHL = 2'd2;
    localparam logic [1:0] OP_LDSP = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_WHI, S_WLO, S_RLO, S_RHI, S_RWAIT, S_XWLO, S_XWHI, S_DONE
    } state_t;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [15:0] data_q;
    logic [7:0]  lo_q;
    logic [15:0] word_q;
    logic [15:0] sp_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_data_q;
    logic        stk_fault_q;
    logic [15:0] mem_addr_q;
    logic        mem_wen_q;
    logic        mem_ren_q;
    logic [7:0]  mem_wdata_q;
    logic        fault_c;

`ifdef STACK_GUARD_EN
    logic [15:0] sp_m2_c;
    assign sp_m2_c = 16'(sp_q - 16'd2);
    // Reject pushes below the limit and pops/exchanges on an empty stack.
    assign fault_c = ((cmd_op == OP_PUSH) && (sp_m2_c < STACK_LIMIT)) ||
                     (((cmd_op == OP_POP) || (cmd_op == OP_XTHL)) && (sp_q == SP_INIT));
`else
    logic unused_limit_c;
    assign unused_limit_c = ^STACK_LIMIT;
    assign fault_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_PUSH;
            data_q      <= 16'h0000;
            lo_q        <= 8'h00;
            word_q      <= 16'h0000;
            sp_q        <= SP_INIT;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            stk_fault_q <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_wdata_q <= 8'h00;
        end else begin
            // Strobes and the response pulse are single-cycle unless re-armed below.
            rsp_valid_q <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_wdata_q <= 8'h00;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= cmd_op;
                        data_q      <= cmd_data;
                        cmd_ready_q <= 1'b0;
                        if (fault_c) begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= 16'h0000;
                            stk_fault_q <= 1'b1;
                        end else begin
                            case (cmd_op)
                                OP_PUSH: begin
                                    state_q     <= S_WHI;
                                    mem_wen_q   <= 1'b1;
                                    mem_addr_q  <= 16'(sp_q - 16'd1);
                                    mem_wdata_q <= cmd_data[15:8];
                                end
                                OP_POP, OP_XTHL: begin
                                    state_q    <= S_RLO;
                                    mem_ren_q  <= 1'b1;
                                    mem_addr_q <= sp_q;
                                end
                                default: begin
                                    state_q     <= S_DONE;
                                    sp_q        <= cmd_data;
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= cmd_data;
                                    stk_fault_q <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                S_WHI: begin
                    state_q     <= S_WLO;
                    mem_wen_q   <= 1'b1;
                    mem_addr_q  <= 16'(sp_q - 16'd2);
                    mem_wdata_q <= data_q[7:0];
                end
                S_WLO: begin
                    state_q     <= S_DONE;
                    sp_q        <= 16'(sp_q - 16'd2);
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= data_q;
                    stk_fault_q <= 1'b0;
                end
                S_RLO: begin
                    state_q    <= S_RHI;
                    mem_ren_q  <= 1'b1;
                    mem_addr_q <= 16'(sp_q + 16'd1);
                end
                S_RHI: begin
                    state_q <= S_RWAIT;
                    lo_q    <= mem_rdata;
                end
                S_RWAIT: begin
                    if (op_q == OP_POP) begin
                        state_q     <= S_DONE;
                        sp_q        <= 16'(sp_q + 16'd2);
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= {mem_rdata, lo_q};
                        stk_fault_q <= 1'b0;
                    end else begin
                        state_q     <= S_XWLO;
                        word_q      <= {mem_rdata, lo_q};
                        mem_wen_q   <= 1'b1;
                        mem_addr_q  <= sp_q;
                        mem_wdata_q <= data_q[7:0];
                    end
                end
                S_XWLO: begin
                    state_q     <= S_XWHI;
                    mem_wen_q   <= 1'b1;
                    mem_addr_q  <= 16'(sp_q + 16'd1);
                    mem_wdata_q <= data_q[15:8];
                end
                S_XWHI: begin
                    state_q     <= S_DONE;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= word_q;
                    stk_fault_q <= 1'b0;
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign stk_fault = stk_fault_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_ren   = mem_ren_q;
    assign mem_wdata = mem_wdata_q;
    assign sp        = sp_q;

endmodule
